// File: rtl/mram_burst_ctrl.sv
// Burst controller driving an asynchronous SRAM-style MRAM: one beat per word, linear or wrapped addressing.
// Latency: read beat = SETUP + ACCESS_CYC + HOLD cycles; rd_valid pulses in HOLD. Writes add >=1 WAIT_WR cycle per beat.
// Backpressure: writes stall in WAIT_WR until wr_valid; reads have none (consumer must take every rd_valid).
module mram_burst_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int LEN_W      = 8,
    parameter int ACCESS_CYC = 3,
    parameter int WRAP_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_wrap,
    input  logic                  abort,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mram_addr,
    output logic [DATA_W-1:0]     mram_dq_o,
    output logic                  mram_dq_oe,
    input  logic [DATA_W-1:0]     mram_dq_i,
    output logic                  chip_en,
    output logic                  write_en,
    output logic                  out_en,
    output logic [DATA_W/8-1:0]   byte_en_n
);

    localparam int ACC_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCESS_CYC - 1);

    typedef enum logic [2:0] {IDLE, WAIT_WR, SETUP, ACCESS, HOLD} state_t;

    state_t            state;
    logic [LEN_W-1:0]  beat_cnt;
    logic [ACC_W-1:0]  acc_cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next_addr;
    logic              is_write;
    logic              is_wrap;
    logic              abort_seen;
    logic              abort_now;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    // A word is only taken when the burst is not being abandoned this cycle.
    assign wr_ready  = (state == WAIT_WR) && wr_valid && !abort && !rst;
    assign abort_now = abort_seen || abort;

    // Next beat address: linear rolls over the full space, wrap stays inside the aligned block.
    always_comb begin
        next_addr = addr + ADDR_W'(1);
        if (is_wrap) begin
            next_addr                = addr;
            next_addr[WRAP_W-1:0]    = addr[WRAP_W-1:0] + WRAP_W'(1);
        end
    end

    // Burst FSM with all pin outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            acc_cnt    <= '0;
            addr       <= '0;
            is_write   <= 1'b0;
            is_wrap    <= 1'b0;
            abort_seen <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            done       <= 1'b0;
            mram_addr  <= '0;
            mram_dq_o  <= '0;
            mram_dq_oe <= 1'b0;
            chip_en    <= 1'b1;
            write_en   <= 1'b1;
            out_en     <= 1'b1;
            byte_en_n  <= '1;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (state != IDLE && abort) begin
                abort_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_write   <= cmd_write;
                        is_wrap    <= cmd_wrap;
                        addr       <= cmd_addr;
                        beat_cnt   <= cmd_len;
                        abort_seen <= 1'b0;
                        if (cmd_write) begin
                            state <= WAIT_WR;
                        end else begin
                            state     <= SETUP;
                            mram_addr <= cmd_addr;
                            chip_en   <= 1'b0;
                            byte_en_n <= '0;
                        end
                    end
                end
                WAIT_WR: begin
                    if (abort) begin
                        // No pin cycle has started for this beat, so leave at once.
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (wr_valid) begin
                        state      <= SETUP;
                        mram_addr  <= addr;
                        mram_dq_o  <= wr_data;
                        mram_dq_oe <= 1'b1;
                        byte_en_n  <= ~wr_be;
                        chip_en    <= 1'b0;
                    end
                end
                SETUP: begin
                    acc_cnt <= '0;
                    state   <= ACCESS;
                    if (is_write) begin
                        write_en <= 1'b0;
                    end else begin
                        out_en <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (acc_cnt == ACC_LAST) begin
                        state    <= HOLD;
                        write_en <= 1'b1;
                        out_en   <= 1'b1;
                        if (!is_write) begin
                            rd_data  <= mram_dq_i;
                            rd_valid <= 1'b1;
                            rd_last  <= (beat_cnt == '0) && !abort_now;
                        end
                    end else begin
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end
                end
                HOLD: begin
                    if (beat_cnt == '0 || abort_now) begin
                        state      <= IDLE;
                        done       <= 1'b1;
                        chip_en    <= 1'b1;
                        mram_dq_oe <= 1'b0;
                        byte_en_n  <= '1;
                    end else begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                        addr     <= next_addr;
                        if (is_write) begin
                            state      <= WAIT_WR;
                            chip_en    <= 1'b1;
                            mram_dq_oe <= 1'b0;
                            byte_en_n  <= '1;
                        end else begin
                            state     <= SETUP;
                            mram_addr <= next_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mram_burst_ctrl.sv
// Bench for mram_burst_ctrl: directed bursts against a small MRAM pin model.
// Expected pin accesses and read beats are queued at issue time; a negedge monitor pops and compares.
// Every DUT wait is bounded; a global watchdog ends the run if anything stalls.
module tb_mram_burst_ctrl;

    localparam int ACCESS_CYC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_wrap;
    logic [19:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        abort;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_valid, rd_last, busy, done;
    logic [15:0] rd_data;
    logic [19:0] mram_addr;
    logic [15:0] mram_dq_o, mram_dq_i;
    logic        mram_dq_oe, chip_en, write_en, out_en;
    logic [1:0]  byte_en_n;

    always #5 clk = ~clk;

    mram_burst_ctrl #(
        .DATA_W(16), .ADDR_W(20), .LEN_W(8), .ACCESS_CYC(ACCESS_CYC), .WRAP_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wrap(cmd_wrap), .abort(abort),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done),
        .mram_addr(mram_addr), .mram_dq_o(mram_dq_o), .mram_dq_oe(mram_dq_oe),
        .mram_dq_i(mram_dq_i), .chip_en(chip_en), .write_en(write_en),
        .out_en(out_en), .byte_en_n(byte_en_n)
    );

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [15:0] d;
        logic [1:0]  ben;
    } acc_t;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } rd_t;

    acc_t exp_acc[$];
    rd_t  exp_rd[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [15:0] mem [0:255];

    // Pad model: drives the bus only while out_en is low.
    assign mram_dq_i = out_en ? 16'hDEAD : mem[mram_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_acc(input logic w, input logic [19:0] a, input logic [15:0] d, input logic [1:0] ben);
        acc_t e;
        e.w = w; e.a = a; e.d = d; e.ben = ben;
        exp_acc.push_back(e);
    endtask

    task automatic push_rd(input logic [15:0] d, input logic l);
        rd_t e;
        e.d = d; e.l = l;
        exp_rd.push_back(e);
    endtask

    task automatic issue(input logic w, input logic [19:0] a, input logic [7:0] len, input logic wrap);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len; cmd_wrap = wrap;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for WAIT_WR (busy with chip disabled), stalls, then offers one word.
    task automatic feed(input logic [15:0] d, input logic [1:0] be, input int stall);
        int t = 0;
        @(negedge clk);
        while (!(busy && chip_en) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_wr_seen", (t < 100), 1);
        for (int k = 0; k < stall; k++) begin
            chk("stall_chip_en", chip_en, 1);
            chk("stall_dq_oe", mram_dq_oe, 0);
            chk("stall_busy", busy, 1);
            @(negedge clk);
        end
        wr_valid = 1'b1; wr_data = d; wr_be = be;
        #1;
        chk("wr_ready", wr_ready, 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", (t < 300), 1);
        exp_done++;
        chk("busy_at_done", busy, 0);
        repeat (2) @(negedge clk);
        chk("done_count", done_cnt, exp_done);
    endtask

    // Memory model: commits enabled byte lanes while the write strobe is low.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hC3, 8'(i)};
        forever begin
            @(negedge clk);
            if (chip_en === 1'b0 && write_en === 1'b0) begin
                if (!byte_en_n[0]) mem[mram_addr[7:0]][7:0]  = mram_dq_o[7:0];
                if (!byte_en_n[1]) mem[mram_addr[7:0]][15:8] = mram_dq_o[15:8];
            end
        end
    end

    // Monitor: pops expectations on each read beat and each strobe start; checks strobe width.
    initial begin
        logic prev_we, prev_oe;
        int   lowcnt;
        acc_t ea;
        rd_t  er;
        prev_we = 1'b1; prev_oe = 1'b1; lowcnt = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rd_data", rd_data, er.d);
                    chk("rd_last", rd_last, er.l);
                end
            end
            if ((write_en === 1'b0 && prev_we) || (out_en === 1'b0 && prev_oe)) begin
                if (exp_acc.size() == 0) begin
                    chk("acc_unexpected", 1, 0);
                end else begin
                    ea = exp_acc.pop_front();
                    chk("acc_dir", !write_en, ea.w);
                    chk("acc_addr", mram_addr, ea.a);
                    chk("acc_chip_en", chip_en, 0);
                    if (ea.w) begin
                        chk("wr_dq", mram_dq_o, ea.d);
                        chk("wr_byte_en_n", byte_en_n, ea.ben);
                        chk("wr_dq_oe", mram_dq_oe, 1);
                    end else begin
                        chk("rd_byte_en_n", byte_en_n, 0);
                        chk("rd_dq_oe", mram_dq_oe, 0);
                    end
                end
            end
            if (write_en === 1'b0 || out_en === 1'b0) begin
                lowcnt++;
            end else begin
                if (lowcnt > 0 && rst === 1'b0) chk("strobe_len", lowcnt, ACCESS_CYC);
                lowcnt = 0;
            end
            prev_we = (write_en !== 1'b0);
            prev_oe = (out_en !== 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d tests run", n_tests);
        $fatal(1);
    end

    // Directed scenarios.
    initial begin
        int   n, t;
        logic prev;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_wrap = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_chip_en", chip_en, 1);
        chk("rst_write_en", write_en, 1);
        chk("rst_out_en", out_en, 1);
        chk("rst_byte_en_n", byte_en_n, 2'b11);
        chk("rst_dq_oe", mram_dq_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_mram_addr", mram_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // Linear write burst then read back.
        for (int i = 0; i < 4; i++) push_acc(1'b1, 20'h00010 + 20'(i), 16'hA001 + 16'(i), 2'b00);
        issue(1'b1, 20'h00010, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) feed(16'hA001 + 16'(i), 2'b11, 0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            push_acc(1'b0, 20'h00010 + 20'(i), '0, '0);
            push_rd(16'hA001 + 16'(i), (i == 3));
        end
        issue(1'b0, 20'h00010, 8'd3, 1'b0);
        wait_done();

        // Wrapped read across the 16-word block; a command while busy is ignored.
        push_acc(1'b0, 20'h0000E, '0, '0); push_rd(16'hC30E, 1'b0);
        push_acc(1'b0, 20'h0000F, '0, '0); push_rd(16'hC30F, 1'b0);
        push_acc(1'b0, 20'h00000, '0, '0); push_rd(16'hC300, 1'b0);
        push_acc(1'b0, 20'h00001, '0, '0); push_rd(16'hC301, 1'b1);
        issue(1'b0, 20'h0000E, 8'd3, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00077; cmd_len = 8'd0;
        #1;
        chk("cmd_ready_while_busy", cmd_ready, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done();

        // Linear read rolling over the top of the address space.
        push_acc(1'b0, 20'hFFFFE, '0, '0); push_rd(16'hC3FE, 1'b0);
        push_acc(1'b0, 20'hFFFFF, '0, '0); push_rd(16'hC3FF, 1'b0);
        push_acc(1'b0, 20'h00000, '0, '0); push_rd(16'hC300, 1'b0);
        push_acc(1'b0, 20'h00001, '0, '0); push_rd(16'hC301, 1'b1);
        issue(1'b0, 20'hFFFFE, 8'd3, 1'b0);
        wait_done();

        // Single write, low byte only; read back shows upper byte untouched.
        push_acc(1'b1, 20'h00020, 16'h55AA, 2'b10);
        issue(1'b1, 20'h00020, 8'd0, 1'b0);
        feed(16'h55AA, 2'b01, 0);
        wait_done();
        push_acc(1'b0, 20'h00020, '0, '0); push_rd(16'hC3AA, 1'b1);
        issue(1'b0, 20'h00020, 8'd0, 1'b0);
        wait_done();

        // Write burst with a 5-cycle stall before the second word.
        push_acc(1'b1, 20'h00030, 16'hB001, 2'b00);
        push_acc(1'b1, 20'h00031, 16'hB002, 2'b00);
        issue(1'b1, 20'h00030, 8'd1, 1'b0);
        feed(16'hB001, 2'b11, 0);
        feed(16'hB002, 2'b11, 5);
        wait_done();
        push_acc(1'b0, 20'h00030, '0, '0); push_rd(16'hB001, 1'b0);
        push_acc(1'b0, 20'h00031, '0, '0); push_rd(16'hB002, 1'b1);
        issue(1'b0, 20'h00030, 8'd1, 1'b0);
        wait_done();

        // Read len=7 aborted during the third beat's ACCESS: three beats, no rd_last.
        for (int i = 0; i < 3; i++) begin
            push_acc(1'b0, 20'h00040 + 20'(i), '0, '0);
            push_rd(16'hC340 + 16'(i), 1'b0);
        end
        issue(1'b0, 20'h00040, 8'd7, 1'b0);
        n = 0; t = 0; prev = 1'b1;
        while (n < 3 && t < 200) begin
            @(negedge clk);
            if (prev && !out_en) n++;
            prev = out_en;
            t++;
        end
        chk("abort_beat_seen", n, 3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done();

        // Reset during a write ACCESS, then a fresh command.
        push_acc(1'b1, 20'h00050, 16'hD001, 2'b00);
        issue(1'b1, 20'h00050, 8'd1, 1'b0);
        feed(16'hD001, 2'b11, 0);
        t = 0;
        @(negedge clk);
        while (write_en !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_strobe_seen", (t < 100), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_chip_en", chip_en, 1);
        chk("midrst_write_en", write_en, 1);
        chk("midrst_out_en", out_en, 1);
        chk("midrst_byte_en_n", byte_en_n, 2'b11);
        chk("midrst_dq_oe", mram_dq_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mram_addr", mram_addr, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        push_acc(1'b0, 20'h00050, '0, '0); push_rd(16'hD001, 1'b0);
        push_acc(1'b0, 20'h00051, '0, '0); push_rd(16'hC351, 1'b1);
        issue(1'b0, 20'h00050, 8'd1, 1'b0);
        wait_done();

        repeat (4) @(negedge clk);
        chk("acc_queue_drained", exp_acc.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("done_total", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mram_burst_ctrl.md
Name: mram_burst_ctrl

Overview:
Parametrised MRAM burst controller; successor to the fixed 16-bit/20-bit SPS burst path. It accepts a command (address, length, direction, wrap mode) over a valid/ready handshake and streams write data in or read data out, one beat per word. It drives the asynchronous SRAM-style MRAM pins with programmable access wait states. It sits between the serial-to-parallel front end and the MRAM pads; the top level owns the tri-state buffer.

Parameters:
DATA_W, 16, MRAM data width; a multiple of 8.
ADDR_W, 20, MRAM word-address width.
LEN_W, 8, burst length field width; beats = cmd_len+1.
ACCESS_CYC, 3, cycles with we_n/oe_n asserted per beat; minimum 1.
WRAP_W, 4, wrap-mode block size = 2^WRAP_W words; WRAP_W < ADDR_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller idle and accepting a command
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start word address
cmd_len  in  LEN_W  beats minus one (0 = single transfer)
cmd_wrap  in  1  1=wrap within aligned 2^WRAP_W block, 0=linear
abort  in  1  stop the burst after the current beat
wr_valid  in  1  write word available
wr_ready  out  1  write word consumed this cycle
wr_data  in  DATA_W  write word
wr_be  in  DATA_W/8  byte enables, active high
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_data  out  DATA_W  read word
rd_last  out  1  high with rd_valid on the final read beat
busy  out  1  burst in progress
done  out  1  one-cycle pulse when a burst completes or is aborted
mram_addr  out  ADDR_W  MRAM address
mram_dq_o  out  DATA_W  data to pad
mram_dq_oe  out  1  pad output enable, active high
mram_dq_i  in  DATA_W  data from pad
chip_en  out  1  chip enable, active low
write_en  out  1  write enable, active low
out_en  out  1  output enable, active low
byte_en_n  out  DATA_W/8  byte lane enables, active low; bit0 = bits 7:0

Behaviour:
- Reset, or any cycle with rst=1: state IDLE; chip_en, write_en and out_en =1; byte_en_n all 1; mram_dq_oe, wr_ready, rd_valid, rd_last, busy and done =0; mram_addr, mram_dq_o and rd_data =0. The pins go inactive on the cycle after rst is sampled, including mid-burst; the burst is discarded.
- All pin outputs are registered; cmd_ready = (state==IDLE) && !rst.
- States: IDLE, WAIT_WR, SETUP, ACCESS, HOLD.
  - IDLE: on cmd_valid&&cmd_ready, latch the command and set beat counter = cmd_len. Go to WAIT_WR if writing, else SETUP.
  - WAIT_WR: chip_en=1. When wr_valid=1, wr_ready pulses for that cycle, data/be are latched, and the FSM goes to SETUP.
  - SETUP (1 cycle): address driven; chip_en=0. Writes: mram_dq_oe=1, byte_en_n=~be. Reads: byte_en_n all 0.
  - ACCESS (ACCESS_CYC cycles): write_en=0 (write) or out_en=0 (read). On the last ACCESS cycle of a read, capture mram_dq_i into rd_data; rd_valid pulses the next cycle.
  - HOLD (1 cycle): write_en and out_en =1; data and address held. Then:
    - if counter==0 or abort was seen: go to IDLE, pulse done, chip_en=1, mram_dq_oe=0;
    - else decrement the counter, advance the address, and go to WAIT_WR (write) or SETUP (read).
- Beat period = ACCESS_CYC+2 cycles (reads); writes add at least 1 WAIT_WR cycle.
- Address advance:
  - linear: +1 modulo 2^ADDR_W, so all-ones wraps to 0;
  - wrap: the low WRAP_W bits increment modulo 2^WRAP_W and the upper bits are unchanged.
- abort: sampled in any non-IDLE state and held internally. The current beat completes through HOLD, then the FSM goes to IDLE. An abort in WAIT_WR goes to IDLE immediately, with no pin cycle. rd_last is not asserted on an aborted burst.
- busy = state != IDLE. A cmd_valid while busy is ignored (not queued).
- Reads have no backpressure: the consumer must accept every rd_valid.

Test Plan:
- Write cmd addr=0x00010, len=3, linear, data 0xA001..0xA004, wr_be=2'b11 → four beats at 0x10..0x13, each write_en low 3 cycles; done pulses once; then read back the same → rd_data A001..A004 with rd_last on the 4th.
- Read cmd addr=0x0000E, len=3, cmd_wrap=1 → mram_addr sequence 0x0000E, 0x0000F, 0x00000, 0x00001. Linear from 0xFFFFE → 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Single write len=0, wr_be=2'b01, data 0x55AA → byte_en_n=2'b10 during SETUP/ACCESS/HOLD; exactly one beat; done pulses.
- Write burst len=1 with wr_valid low for 5 cycles before the 2nd word → FSM stays in WAIT_WR, chip_en=1 and mram_dq_oe=0 during the stall; second beat resumes correctly.
- Read len=7, abort asserted during beat 2's ACCESS → beat 2 completes, done pulses after its HOLD, 3 rd_valid pulses total, rd_last never set.
- rst asserted mid-ACCESS of a write → next cycle all pins inactive, cmd_ready=1 after rst drops, and a new command executes normally.
